sq_submit_scheduler: RTL and testbench
======================================

// Module: sq_submit_scheduler
// PURPOSE
// Shares one NVMe submission queue (SQ) among NUM_REQ command sources. Round-robin arbitration picks
// a source and hands the next free SQ slot address to the AXI write engine, which copies the 64-byte
// command. The block tracks tail/head pointers and coalesces tail-doorbell writes. It sits between
// the command generators and the SubmissionQueueManagement AXI master / doorbell path.
// PARAMETERS
// NUM_REQ   4   number of requesters (2..8)
// ADDR_W    64  host address width
// QPTR_W    16  queue pointer / size width
// DB_BATCH  4   max commands written before a doorbell is forced (>=1)
// PORTS
// ACLK         in   1          clock
// ARESET       in   1          synchronous, active-high reset
// cfg_enable   in   1          scheduler enable
// cfg_sq_base  in   ADDR_W     SQ base address, 64-byte aligned; static while cfg_enable=1
// cfg_sq_size  in   QPTR_W     SQ entry count, 2..2^QPTR_W-1; static while cfg_enable=1
// req          in   NUM_REQ    per-source request, level; held until matching gnt bit falls
// gnt          out  NUM_REQ    one-hot grant, high from issue until wr_done
// wr_valid     out  1          slot write request to AXI write engine
// wr_ready     in   1          write engine accepts request
// wr_addr      out  ADDR_W     cfg_sq_base + tail*64
// wr_src       out  $clog2(NUM_REQ)  granted source index
// wr_done      in   1          single-cycle pulse: command copy finished
// wr_err       in   1          qualified by wr_done: copy failed
// db_valid     out  1          doorbell write request
// db_ready     in   1          doorbell accepted
// db_tail      out  QPTR_W     new tail value to write
// head_valid   in   1          SQ head update from completion path
// head_ptr     in   QPTR_W     new SQ head
// sq_full      out  1          (tail+1) mod size == head
// sq_empty     out  1          tail == head
// err          out  1          sticky error
// BEHAVIOUR
// - Reset: state IDLE; gnt=0, wr_valid=0, db_valid=0, err=0; tail=head=pending=0; rr pointer=0;
//   sq_empty=1, sq_full=0. Reset mid-operation aborts immediately; no doorbell is flushed.
// - FSM IDLE->ISSUE->WAIT->(DOORBELL)->IDLE/ISSUE.
//   IDLE: if cfg_enable & |req & !sq_full -> ISSUE next cycle. Winner = first set req at or after
//   rr pointer (wraps). wr_valid, gnt, wr_addr and wr_src are registered, all valid in the same cycle.
//   ISSUE: hold wr_valid/wr_addr/wr_src stable until wr_valid&wr_ready; then wr_valid=0 -> WAIT.
//   WAIT: on wr_done: gnt=0 next cycle, rr pointer = winner+1 mod NUM_REQ.
//     !wr_err: tail = (tail+1==size) ? 0 : tail+1; pending++.
//     wr_err:  tail unchanged, err=1, pending unchanged; source may re-request.
//     Then DOORBELL if pending>=1 and (pending==DB_BATCH, no eligible req, sq_full or !cfg_enable);
//     else ISSUE with next winner directly (no IDLE bubble).
//   DOORBELL: db_valid=1, db_tail=tail held until db_ready; then pending=0 -> IDLE.
// - Only one command outstanding; wr_done outside WAIT ignored and sets err.
// - Head: head_valid loads head_ptr in any state. head_ptr>=cfg_sq_size is ignored, err=1.
//   sq_full/sq_empty are combinational from registered head/tail. Same-cycle head update and tail
//   advance are both applied.
// - Full: arbitration is blocked while sq_full; usable depth = size-1.
// - Deassert cfg_enable: the current command completes and pending doorbell is flushed, then IDLE.
//   While !cfg_enable in IDLE, head, tail and rr are held at 0.
// - err clears only on ARESET.
// TESTING
// 1 size=8, base=0x1000, req=0001, wr_ready=1, wr_done 3 cycles later -> wr_addr=0x1000, gnt=0001,
//   tail=1, db_valid with db_tail=1 (no further req).
// 2 req=1111 held, DB_BATCH=4 -> grants 0001,0010,0100,1000 in order; one doorbell db_tail=4.
// 3 size=4, head fixed 0 -> 3 commands then sq_full=1, no 4th grant. head_ptr=2 -> 2 more commands;
//   tail wraps 3->0, wr_addr=base+0.
// 4 wr_err with wr_done -> tail unchanged, err=1, same slot address reissued on retry.
// 5 db_ready low 10 cycles -> db_valid/db_tail stable, no new gnt; head_ptr=9 with size=8 -> ignored, err=1.
// 6 ARESET during ISSUE -> next cycle all outputs at reset values, tail=0.

Source files
------------

// File: rtl/sq_submit_scheduler.sv
// Round-robin sharing of one NVMe submission queue among NUM_REQ command sources.
// Issues one slot write at a time, tracks head/tail and coalesces tail doorbells.
module sq_submit_scheduler #(
  parameter int NUM_REQ  = 4,
  parameter int ADDR_W   = 64,
  parameter int QPTR_W   = 16,
  parameter int DB_BATCH = 4,
  localparam int SRC_W   = $clog2(NUM_REQ),
  localparam int PEND_W  = $clog2(DB_BATCH + 1)
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic                cfg_enable,
  input  logic [ADDR_W-1:0]   cfg_sq_base,
  input  logic [QPTR_W-1:0]   cfg_sq_size,
  input  logic [NUM_REQ-1:0]  req,
  output logic [NUM_REQ-1:0]  gnt,
  output logic                wr_valid,
  input  logic                wr_ready,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [SRC_W-1:0]    wr_src,
  input  logic                wr_done,
  input  logic                wr_err,
  output logic                db_valid,
  input  logic                db_ready,
  output logic [QPTR_W-1:0]   db_tail,
  input  logic                head_valid,
  input  logic [QPTR_W-1:0]   head_ptr,
  output logic                sq_full,
  output logic                sq_empty,
  output logic                err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DOORBELL} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [SRC_W-1:0]  src;
  } wr_req_t;

  typedef struct packed {
    logic             found;
    logic [SRC_W-1:0] idx;
  } pick_t;

  state_t              state;
  wr_req_t             wr_q;
  logic [QPTR_W-1:0]   tail, head;
  logic [PEND_W-1:0]   pending;
  logic [SRC_W-1:0]    rr;

  function automatic logic [QPTR_W-1:0] ptr_inc(input logic [QPTR_W-1:0] p,
                                                 input logic [QPTR_W-1:0] size);
    logic [QPTR_W-1:0] n;
    n = p + QPTR_W'(1);
    return (n == size) ? '0 : n;
  endfunction

  function automatic logic [ADDR_W-1:0] slot_addr(input logic [QPTR_W-1:0] p);
    return cfg_sq_base + (ADDR_W'(p) << 6);
  endfunction

  // First set bit at or after start, wrapping.
  function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] r, input logic [SRC_W-1:0] start);
    pick_t res;
    int    j;
    res = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(start) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!res.found && r[j]) begin
        res.found = 1'b1;
        res.idx   = SRC_W'(j);
      end
    end
    return res;
  endfunction

  logic [QPTR_W-1:0] tail_inc, tail_after, head_nxt;
  logic [PEND_W-1:0] pend_after;
  logic [SRC_W-1:0]  rr_after;
  logic              head_ok, done_ok, full_after, elig_w;
  pick_t             pick_idle, pick_wait;

  always_comb begin
    tail_inc   = ptr_inc(tail, cfg_sq_size);
    sq_full    = (tail_inc == head);
    sq_empty   = (tail == head);
    head_ok    = head_valid && (head_ptr < cfg_sq_size);
    head_nxt   = head_ok ? head_ptr : head;
    done_ok    = wr_done && !wr_err;
    tail_after = done_ok ? tail_inc : tail;
    pend_after = done_ok ? pending + PEND_W'(1) : pending;
    rr_after   = (wr_q.src == SRC_W'(NUM_REQ - 1)) ? '0 : wr_q.src + SRC_W'(1);
    full_after = (ptr_inc(tail_after, cfg_sq_size) == head_nxt);
    pick_idle  = rr_pick(req, rr);
    // The finishing source still holds req until its gnt falls, so mask it out.
    pick_wait  = rr_pick(req & ~gnt, rr_after);
    elig_w     = cfg_enable && pick_wait.found && !full_after;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state    <= IDLE;
      gnt      <= '0;
      wr_valid <= 1'b0;
      wr_q     <= '0;
      db_valid <= 1'b0;
      db_tail  <= '0;
      tail     <= '0;
      head     <= '0;
      pending  <= '0;
      rr       <= '0;
      err      <= 1'b0;
    end else begin
      if (wr_done && state != WAIT) err <= 1'b1;
      if (head_valid) begin
        if (head_ok) head <= head_ptr;
        else         err  <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (!cfg_enable) begin
            head <= '0;
            tail <= '0;
            rr   <= '0;
          end else if (pick_idle.found && !sq_full) begin
            gnt       <= NUM_REQ'(1) << pick_idle.idx;
            wr_valid  <= 1'b1;
            wr_q.addr <= slot_addr(tail);
            wr_q.src  <= pick_idle.idx;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (wr_ready) begin
            wr_valid <= 1'b0;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (wr_done) begin
            gnt <= '0;
            rr  <= rr_after;
            if (wr_err) err <= 1'b1;
            else begin
              tail    <= tail_inc;
              pending <= pend_after;
            end
            if (pend_after != '0 && (pend_after == PEND_W'(DB_BATCH) || !elig_w)) begin
              db_valid <= 1'b1;
              db_tail  <= tail_after;
              state    <= DOORBELL;
            end else if (elig_w) begin
              gnt       <= NUM_REQ'(1) << pick_wait.idx;
              wr_valid  <= 1'b1;
              wr_q.addr <= slot_addr(tail_after);
              wr_q.src  <= pick_wait.idx;
              state     <= ISSUE;
            end else begin
              state <= IDLE;
            end
          end
        end
        DOORBELL: begin
          if (db_ready) begin
            db_valid <= 1'b0;
            pending  <= '0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign wr_addr = wr_q.addr;
  assign wr_src  = wr_q.src;

endmodule

// File: tb/tb_sq_submit_scheduler.sv
// Directed bench for sq_submit_scheduler: arbitration order, slot addressing,
// doorbell coalescing, full/wrap, error paths and reset abort.
module tb_sq_submit_scheduler;
  localparam int NUM_REQ = 4, ADDR_W = 64, QPTR_W = 16, DB_BATCH = 4;
  localparam logic [ADDR_W-1:0] BASE = 64'h1000;

  logic                ACLK = 1'b0;
  logic                ARESET;
  logic                cfg_enable;
  logic [ADDR_W-1:0]   cfg_sq_base;
  logic [QPTR_W-1:0]   cfg_sq_size;
  logic [NUM_REQ-1:0]  req;
  logic [NUM_REQ-1:0]  gnt;
  logic                wr_valid, wr_ready, wr_done, wr_err;
  logic [ADDR_W-1:0]   wr_addr;
  logic [1:0]          wr_src;
  logic                db_valid, db_ready;
  logic [QPTR_W-1:0]   db_tail;
  logic                head_valid;
  logic [QPTR_W-1:0]   head_ptr;
  logic                sq_full, sq_empty, err;

  int checks = 0;
  int errors = 0;

  always #5 ACLK = ~ACLK;

  sq_submit_scheduler #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .QPTR_W(QPTR_W), .DB_BATCH(DB_BATCH)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .cfg_enable(cfg_enable), .cfg_sq_base(cfg_sq_base),
    .cfg_sq_size(cfg_sq_size), .req(req), .gnt(gnt), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_src(wr_src), .wr_done(wr_done), .wr_err(wr_err), .db_valid(db_valid),
    .db_ready(db_ready), .db_tail(db_tail), .head_valid(head_valid), .head_ptr(head_ptr),
    .sq_full(sq_full), .sq_empty(sq_empty), .err(err));

  task automatic do_reset(input logic [QPTR_W-1:0] size);
    @(negedge ACLK);
    ARESET = 1'b1; cfg_enable = 1'b1; cfg_sq_base = BASE; cfg_sq_size = size;
    req = '0; wr_ready = 1'b1; wr_done = 1'b0; wr_err = 1'b0; db_ready = 1'b0;
    head_valid = 1'b0; head_ptr = '0;
    repeat (2) @(negedge ACLK);
    ARESET = 1'b0;
  endtask

  // Bounded wait for a write request; returns at a negedge with wr_valid high.
  task automatic wait_issue(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (wr_valid) begin ok = 1'b1; break; end
      @(negedge ACLK);
    end
  endtask

  // Handshake happens at the next edge (wr_ready=1); wr_done follows two cycles later.
  task automatic finish_cmd(input bit e);
    @(negedge ACLK);
    @(negedge ACLK);
    wr_done = 1'b1; wr_err = e;
    @(negedge ACLK);
    wr_done = 1'b0; wr_err = 1'b0;
  endtask

  task automatic db_ack();
    db_ready = 1'b1;
    @(negedge ACLK);
    db_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(16'd8);
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rst_gnt: got %b exp 0000", gnt); end
    checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL rst_wr_valid: got %b exp 0", wr_valid); end
    checks++; if (db_valid !== 1'b0) begin errors++; $display("FAIL rst_db_valid: got %b exp 0", db_valid); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b exp 0", err); end
    checks++; if (sq_empty !== 1'b1 || sq_full !== 1'b0) begin
      errors++; $display("FAIL rst_flags: got empty=%b full=%b exp empty=1 full=0", sq_empty, sq_full); end
  endtask

  task automatic test_single();
    bit ok;
    do_reset(16'd8);
    req = 4'b0001;
    wait_issue(ok);
    checks++; if (!ok) begin errors++; $display("FAIL t1_issue_timeout: got none exp wr_valid"); end
    checks++; if (wr_addr !== 64'h1000) begin errors++; $display("FAIL t1_addr: got %h exp 1000", wr_addr); end
    checks++; if (gnt !== 4'b0001 || wr_src !== 2'd0) begin
      errors++; $display("FAIL t1_gnt: got gnt=%b src=%0d exp 0001/0", gnt, wr_src); end
    finish_cmd(1'b0);
    req = 4'b0000;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL t1_gnt_drop: got %b exp 0000", gnt); end
    checks++; if (db_valid !== 1'b1 || db_tail !== 16'd1) begin
      errors++; $display("FAIL t1_db: got valid=%b tail=%0d exp 1/1", db_valid, db_tail); end
    checks++; if (sq_empty !== 1'b0) begin errors++; $display("FAIL t1_empty: got %b exp 0", sq_empty); end
    db_ack();
    checks++; if (db_valid !== 1'b0) begin errors++; $display("FAIL t1_db_clear: got %b exp 0", db_valid); end
  endtask

  task automatic test_round_robin();
    bit ok;
    logic [NUM_REQ-1:0] eg;
    do_reset(16'd8);
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      wait_issue(ok);
      eg = 4'b0001 << k;
      checks++; if (!ok || gnt !== eg || wr_src !== 2'(k)) begin
        errors++; $display("FAIL t2_gnt%0d: got gnt=%b src=%0d exp %b/%0d", k, gnt, wr_src, eg, k); end
      checks++; if (wr_addr !== BASE + 64'(k) * 64) begin
        errors++; $display("FAIL t2_addr%0d: got %h exp %h", k, wr_addr, BASE + 64'(k) * 64); end
      finish_cmd(1'b0);
      req[k] = 1'b0;
      if (k < 3) begin
        checks++; if (db_valid !== 1'b0) begin errors++; $display("FAIL t2_early_db%0d: got %b exp 0", k, db_valid); end
      end
    end
    checks++; if (db_valid !== 1'b1 || db_tail !== 16'd4) begin
      errors++; $display("FAIL t2_db: got valid=%b tail=%0d exp 1/4", db_valid, db_tail); end
    db_ack();
  endtask

  task automatic test_full_wrap();
    bit ok;
    do_reset(16'd4);
    for (int k = 0; k < 3; k++) begin
      req[0] = 1'b1;
      wait_issue(ok);
      checks++; if (!ok || wr_addr !== BASE + 64'(k) * 64) begin
        errors++; $display("FAIL t3_addr%0d: got %h exp %h", k, wr_addr, BASE + 64'(k) * 64); end
      finish_cmd(1'b0);
      req[0] = 1'b0;
      checks++; if (db_valid !== 1'b1 || db_tail !== 16'(k + 1)) begin
        errors++; $display("FAIL t3_db%0d: got valid=%b tail=%0d exp 1/%0d", k, db_valid, db_tail, k + 1); end
      db_ack();
    end
    checks++; if (sq_full !== 1'b1) begin errors++; $display("FAIL t3_full: got %b exp 1", sq_full); end
    req[0] = 1'b1;
    repeat (5) @(negedge ACLK);
    checks++; if (gnt !== 4'b0000 || wr_valid !== 1'b0) begin
      errors++; $display("FAIL t3_blocked: got gnt=%b wr_valid=%b exp 0000/0", gnt, wr_valid); end
    head_valid = 1'b1; head_ptr = 16'd2;
    @(negedge ACLK);
    head_valid = 1'b0;
    wait_issue(ok);
    checks++; if (!ok || wr_addr !== 64'h10C0) begin errors++; $display("FAIL t3_addr3: got %h exp 10c0", wr_addr); end
    finish_cmd(1'b0);
    req[0] = 1'b0;
    checks++; if (db_tail !== 16'd0) begin errors++; $display("FAIL t3_wrap_tail: got %0d exp 0", db_tail); end
    db_ack();
    req[0] = 1'b1;
    wait_issue(ok);
    checks++; if (!ok || wr_addr !== 64'h1000) begin errors++; $display("FAIL t3_wrap_addr: got %h exp 1000", wr_addr); end
    finish_cmd(1'b0);
    req[0] = 1'b0;
    db_ack();
    checks++; if (sq_full !== 1'b1) begin errors++; $display("FAIL t3_full2: got %b exp 1", sq_full); end
  endtask

  task automatic test_wr_err();
    bit ok;
    do_reset(16'd8);
    req = 4'b0001;
    wait_issue(ok);
    finish_cmd(1'b1);
    checks++; if (err !== 1'b1 || gnt !== 4'b0000) begin
      errors++; $display("FAIL t4_err: got err=%b gnt=%b exp 1/0000", err, gnt); end
    checks++; if (sq_empty !== 1'b1 || db_valid !== 1'b0) begin
      errors++; $display("FAIL t4_tail_held: got empty=%b db=%b exp 1/0", sq_empty, db_valid); end
    wait_issue(ok);
    checks++; if (!ok || wr_addr !== 64'h1000 || gnt !== 4'b0001) begin
      errors++; $display("FAIL t4_retry: got addr=%h gnt=%b exp 1000/0001", wr_addr, gnt); end
    finish_cmd(1'b0);
    req = 4'b0000;
    checks++; if (db_valid !== 1'b1 || db_tail !== 16'd1) begin
      errors++; $display("FAIL t4_db: got valid=%b tail=%0d exp 1/1", db_valid, db_tail); end
    db_ack();
  endtask

  task automatic test_db_stall();
    bit ok;
    int bad;
    do_reset(16'd8);
    req = 4'b0001;
    wait_issue(ok);
    finish_cmd(1'b0);
    req = 4'b0010;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (db_valid !== 1'b1 || db_tail !== 16'd1 || gnt !== 4'b0000) bad++;
      @(negedge ACLK);
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL t5_stall: got %0d bad cycles exp 0", bad); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL t5_err_pre: got %b exp 0", err); end
    head_valid = 1'b1; head_ptr = 16'd9;
    @(negedge ACLK);
    head_valid = 1'b0;
    checks++; if (err !== 1'b1 || sq_empty !== 1'b0) begin
      errors++; $display("FAIL t5_bad_head: got err=%b empty=%b exp 1/0", err, sq_empty); end
    db_ack();
    wait_issue(ok);
    checks++; if (!ok || gnt !== 4'b0010 || wr_addr !== 64'h1040) begin
      errors++; $display("FAIL t5_next: got gnt=%b addr=%h exp 0010/1040", gnt, wr_addr); end
  endtask

  task automatic test_spurious_done();
    do_reset(16'd8);
    @(negedge ACLK);
    wr_done = 1'b1;
    @(negedge ACLK);
    wr_done = 1'b0;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL t_spurious: got err=%b exp 1", err); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset(16'd8);
    req = 4'b0001;
    wait_issue(ok);
    finish_cmd(1'b0);
    req = 4'b0000;
    db_ack();
    req = 4'b0001;
    wr_ready = 1'b0;
    wait_issue(ok);
    checks++; if (!ok || wr_addr !== 64'h1040) begin errors++; $display("FAIL t6_pre_addr: got %h exp 1040", wr_addr); end
    ARESET = 1'b1;
    @(negedge ACLK);
    checks++; if (gnt !== 4'b0000 || wr_valid !== 1'b0 || db_valid !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL t6_outs: got gnt=%b wv=%b dbv=%b err=%b exp 0000/0/0/0", gnt, wr_valid, db_valid, err); end
    checks++; if (sq_empty !== 1'b1 || sq_full !== 1'b0) begin
      errors++; $display("FAIL t6_flags: got empty=%b full=%b exp 1/0", sq_empty, sq_full); end
    ARESET = 1'b0;
    wr_ready = 1'b1;
    wait_issue(ok);
    checks++; if (!ok || wr_addr !== 64'h1000) begin errors++; $display("FAIL t6_tail0: got %h exp 1000", wr_addr); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_full_wrap();
    test_wr_err();
    test_db_stall();
    test_spurious_done();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
